// File: rtl/vram_bridge.sv
// vram_bridge: CPU byte-bus front end for the two video RAM banks.
// Writes are posted into a small FIFO and drained one per cycle; reads wait
// for the FIFO to empty, then do a fixed two-cycle RAM access and return the
// byte with a one-cycle cpu_valid pulse.
module vram_bridge #(
  parameter int          DEPTH  = 4,
  parameter logic [19:0] BASE_A = 20'hB8000,
  parameter logic [19:0] BASE_B = 20'hA0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_a,
  input  logic [7:0]  cpu_o,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_i,
  output logic        cpu_valid,
  output logic [12:0] vm_a,
  output logic [7:0]  vm_d,
  output logic        vm_wa,
  output logic        vm_wb,
  input  logic [7:0]  vm_qa,
  input  logic [7:0]  vm_qb
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, RD_ADDR, RD_DATA} state_t;

  typedef struct packed {
    logic        bank_b;
    logic [12:0] off;
    logic [7:0]  data;
  } wr_ent_t;

  // state
  state_t        state_q, state_d;
  wr_ent_t       mem_q [DEPTH];
  wr_ent_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [12:0]   rd_off_q, rd_off_d;
  logic          rd_hit_a_q, rd_hit_a_d;
  logic          rd_hit_b_q, rd_hit_b_d;
  logic [7:0]    cpu_i_q, cpu_i_d;
  logic          cpu_valid_q, cpu_valid_d;

  // combinational helpers
  logic          hit_a, hit_b, accept, push, pop, empty, full;
  logic [20:0]   a_x;
  wr_ent_t       head;

  // Address decode: 21-bit compares so a window near the top of the map cannot wrap.
  always_comb begin
    a_x   = {1'b0, cpu_a};
    hit_a = (a_x >= {1'b0, BASE_A}) && (a_x < ({1'b0, BASE_A} + 21'h2000));
    hit_b = (a_x >= {1'b0, BASE_B}) && (a_x < ({1'b0, BASE_B} + 21'h2000));
  end

  // Handshake, write FIFO push/pop and the RAM write port.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vm_a     = '0;
    vm_d     = '0;
    vm_wa    = 1'b0;
    vm_wb    = 1'b0;

    empty   = (count_q == '0);
    full    = (count_q == CNT_FULL);
    cpu_rdy = (state_q == IDLE) && !full;
    accept  = cpu_req && cpu_rdy;
    // Unmapped writes are acknowledged but never enter the FIFO.
    push    = accept && cpu_we && (hit_a || hit_b);
    // The RAM address port belongs to the read during RD_ADDR/RD_DATA.
    pop     = !empty && (state_q != RD_ADDR) && (state_q != RD_DATA);
    head    = mem_q[rd_ptr_q];

    if (push) begin
      mem_d[wr_ptr_q] = '{bank_b: !hit_a, off: cpu_a[12:0], data: cpu_o};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      vm_a     = head.off;
      vm_d     = head.data;
      vm_wa    = !head.bank_b;
      vm_wb    = head.bank_b;
    end else if (state_q == RD_ADDR) begin
      vm_a = rd_off_q;
    end

    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  // Read sequencing: wait for posted writes to drain, then address and capture.
  always_comb begin
    state_d     = state_q;
    rd_off_d    = rd_off_q;
    rd_hit_a_d  = rd_hit_a_q;
    rd_hit_b_d  = rd_hit_b_q;
    cpu_i_d     = cpu_i_q;
    cpu_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && !cpu_we) begin
          rd_off_d   = cpu_a[12:0];
          rd_hit_a_d = hit_a;
          rd_hit_b_d = hit_b && !hit_a;
          // A lone entry is popped this very cycle, so the read may go straight out.
          state_d    = (count_q <= CNT_ONE) ? RD_ADDR : DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == CNT_ONE) state_d = RD_ADDR;
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        cpu_i_d     = rd_hit_a_q ? vm_qa : (rd_hit_b_q ? vm_qb : 8'hFF);
        cpu_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops queued writes and any read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_off_q    <= '0;
      rd_hit_a_q  <= 1'b0;
      rd_hit_b_q  <= 1'b0;
      cpu_i_q     <= 8'hFF;
      cpu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_off_q    <= rd_off_d;
      rd_hit_a_q  <= rd_hit_a_d;
      rd_hit_b_q  <= rd_hit_b_d;
      cpu_i_q     <= cpu_i_d;
      cpu_valid_q <= cpu_valid_d;
    end
  end

  assign cpu_i     = cpu_i_q;
  assign cpu_valid = cpu_valid_q;

endmodule
